cache_mem_arbiter: RTL and testbench

Memory-side responder for the cache-to-controller interface: services icache reads and dcache reads/writes issued on the `caches` modport and drives `iwait`/`dwait`/`iload`/`dload` back. It arbitrates the two requesters onto a single-ported RAM that has variable latency. Data requests have priority, with a starvation guard for instruction fetch and a timeout for stalled RAM accesses. It sits between the cache pair and the RAM model or bus.

---
 rtl/caches_pkg.sv | 20 ++
 rtl/arb_sat_counter.sv | 24 ++
 rtl/cache_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/caches_pkg.sv
// Shared types for the cache-to-memory interface: data word, RAM handshake
// state and the memory arbiter FSM encoding.
package caches_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; the count holds once it reaches MAX.
module arb_sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    // count register: clear wins, otherwise step until saturated
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != MAX))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Memory-side responder for the icache/dcache pair. Grants one requester at a
// time onto a single-ported variable-latency RAM. Data has priority; after
// STARVE_LIMIT data grants taken while an instruction fetch waits, the fetch
// is forced through. A service that sees no ACCESS/ERROR for TIMEOUT cycles
// completes as an error.
//
//   state | meaning
//   IDLE  | no RAM strobes, choose the next requester
//   DSERV | dcache request driven to RAM, waiting for ACCESS/ERROR
//   ISERV | icache request driven to RAM, waiting for ACCESS/ERROR
module cache_mem_arbiter
    import caches_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      bus_err,
    output logic      proto_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t    state, next_state;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] streak;
    logic          t_inc, t_clr, s_inc, s_clr;
    logic          d_req, forced, t_expired;

    assign d_req     = dREN | dWEN;
    assign forced    = iREN && (streak == SW'(STARVE_LIMIT));
    assign t_expired = (tcnt == TW'(TIMEOUT - 1));
    assign t_clr     = (state == IDLE);

    arb_sat_counter #(.WIDTH(TW), .MAX(TW'(TIMEOUT - 1))) u_tcnt (
        .clk (CLK),
        .rst (RST),
        .clr (t_clr),
        .inc (t_inc),
        .cnt (tcnt)
    );

    arb_sat_counter #(.WIDTH(SW), .MAX(SW'(STARVE_LIMIT))) u_streak (
        .clk (CLK),
        .rst (RST),
        .clr (s_clr),
        .inc (s_inc),
        .cnt (streak)
    );

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= next_state;
    end

    // sticky flag for a dcache asserting read and write together
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            proto_err <= 1'b0;
        else if (dREN && dWEN)
            proto_err <= 1'b1;
    end

    // grant decision, RAM drive and completion; outputs follow cache inputs
    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        bus_err    = 1'b0;
        t_inc      = 1'b0;
        s_inc      = 1'b0;
        s_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !forced) begin
                    next_state = DSERV;
                    s_inc      = iREN;
                end else if (iREN) begin
                    next_state = ISERV;
                    s_clr      = 1'b1;
                end
                if (!iREN)
                    s_clr = 1'b1;
            end
            DSERV: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (ramstate == ACCESS) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        next_state = IDLE;
                    end else if ((ramstate == ERROR) || t_expired) begin
                        dwait      = 1'b0;
                        bus_err    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        t_inc = 1'b1;
                    end
                end
            end
            ISERV: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (ramstate == ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        next_state = IDLE;
                    end else if ((ramstate == ERROR) || t_expired) begin
                        iwait      = 1'b0;
                        bus_err    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        t_inc = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: reset values, dcache read/write,
// error and abort paths, starvation guard, timeout and reset mid-access.
module tb_cache_mem_arbiter;
    import caches_pkg::*;

    logic      CLK;
    logic      RST;
    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      iwait;
    logic      dwait;
    word_t     iload;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      bus_err;
    logic      proto_err;

    int n_tests = 0;
    int n_fail  = 0;

    cache_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .iwait     (iwait),
        .dwait     (dwait),
        .iload     (iload),
        .dload     (dload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .bus_err   (bus_err),
        .proto_err (proto_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // move to 2 time units after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int  bad;
        logic exp_i;

        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #3;
        chk("rst_iwait",     iwait,     32'd1);
        chk("rst_dwait",     dwait,     32'd1);
        chk("rst_ramREN",    ramREN,    32'd0);
        chk("rst_ramWEN",    ramWEN,    32'd0);
        chk("rst_ramaddr",   ramaddr,   32'd0);
        chk("rst_ramstore",  ramstore,  32'd0);
        chk("rst_iload",     iload,     32'd0);
        chk("rst_dload",     dload,     32'd0);
        chk("rst_bus_err",   bus_err,   32'd0);
        chk("rst_proto_err", proto_err, 32'd0);
        tick(); RST = 1'b0;
        tick();

        // dcache read, three BUSY cycles then ACCESS
        dREN = 1'b1; daddr = 32'h100; #1;
        chk("rd_c0_ramREN", ramREN, 32'd0);
        chk("rd_c0_dwait",  dwait,  32'd1);
        tick(); ramstate = BUSY; #1;
        chk("rd_c1_ramREN",  ramREN,  32'd1);
        chk("rd_c1_ramaddr", ramaddr, 32'h100);
        chk("rd_c1_dwait",   dwait,   32'd1);
        tick(); #1; chk("rd_c2_dwait", dwait, 32'd1);
        tick(); #1; chk("rd_c3_dwait", dwait, 32'd1);
        tick(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
        chk("rd_c4_dwait", dwait, 32'd0);
        chk("rd_c4_dload", dload, 32'hDEADBEEF);
        chk("rd_c4_iwait", iwait, 32'd1);
        tick(); #1;
        chk("rd_c5_dwait",  dwait,  32'd1);
        chk("rd_c5_ramREN", ramREN, 32'd0);
        dREN = 1'b0; ramstate = FREE; ramload = '0;
        tick();

        // dcache write
        dWEN = 1'b1; daddr = 32'h40; dstore = 32'h12345678; #1;
        tick(); ramstate = BUSY; #1;
        chk("wr_c1_ramWEN",   ramWEN,   32'd1);
        chk("wr_c1_ramREN",   ramREN,   32'd0);
        chk("wr_c1_ramaddr",  ramaddr,  32'h40);
        chk("wr_c1_ramstore", ramstore, 32'h12345678);
        chk("wr_c1_dwait",    dwait,    32'd1);
        tick(); ramstate = ACCESS; ramload = 32'h0BADF00D; #1;
        chk("wr_c2_ramWEN", ramWEN, 32'd1);
        chk("wr_c2_ramREN", ramREN, 32'd0);
        chk("wr_c2_dwait",  dwait,  32'd0);
        chk("wr_c2_dload",  dload,  32'h0BADF00D);
        dWEN = 1'b0; ramstate = FREE; ramload = '0;
        tick(); #1;
        chk("wr_c3_dwait",  dwait,  32'd1);
        chk("wr_c3_ramWEN", ramWEN, 32'd0);

        // RAM ERROR response
        dREN = 1'b1; daddr = 32'h180;
        tick(); ramstate = ERROR; ramload = 32'hFFFFFFFF; #1;
        chk("err_dwait",   dwait,   32'd0);
        chk("err_dload",   dload,   32'd0);
        chk("err_bus_err", bus_err, 32'd1);
        dREN = 1'b0; ramstate = FREE; ramload = '0;
        tick(); #1;
        chk("err_next_bus_err", bus_err, 32'd0);

        // abort: dcache drops its request mid-service
        dREN = 1'b1; daddr = 32'h1C0;
        tick(); ramstate = BUSY; #1;
        chk("abt_c1_ramREN", ramREN, 32'd1);
        tick(); dREN = 1'b0; #1;
        chk("abt_c2_ramREN",  ramREN,  32'd0);
        chk("abt_c2_dwait",   dwait,   32'd1);
        chk("abt_c2_bus_err", bus_err, 32'd0);
        tick(); iREN = 1'b1; iaddr = 32'h240;
        tick(); ramstate = ACCESS; ramload = 32'h600DF00D; #1;
        chk("abt_i_iwait",   iwait,   32'd0);
        chk("abt_i_iload",   iload,   32'h600DF00D);
        chk("abt_i_ramaddr", ramaddr, 32'h240);
        iREN = 1'b0; ramstate = FREE; ramload = '0;
        tick();

        // starvation guard: both requesting, zero-wait RAM
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h200; daddr = 32'h300;
        ramstate = ACCESS; ramload = 32'hCAFE0001;
        for (int k = 0; k < 10; k++) begin
            exp_i = ((k % 5) == 4);
            tick(); #1;
            chk($sformatf("stv%0d_iwait", k),   iwait,   exp_i ? 32'd0 : 32'd1);
            chk($sformatf("stv%0d_dwait", k),   dwait,   exp_i ? 32'd1 : 32'd0);
            chk($sformatf("stv%0d_ramaddr", k), ramaddr, exp_i ? 32'h200 : 32'h300);
            tick(); #1;
            chk($sformatf("stv%0d_idle_ramREN", k), ramREN, 32'd0);
        end
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE; ramload = '0;
        tick();

        // timeout on a stuck-BUSY instruction fetch
        iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY; ramload = 32'hFFFFFFFF;
        tick();
        bad = 0;
        for (int c = 1; c < 64; c++) begin
            #1;
            if (iwait !== 1'b1 || bus_err !== 1'b0 || ramREN !== 1'b1) bad++;
            tick();
        end
        #1;
        chk("to_early_cycles", bad,     32'd0);
        chk("to_c64_iwait",    iwait,   32'd0);
        chk("to_c64_iload",    iload,   32'd0);
        chk("to_c64_bus_err",  bus_err, 32'd1);
        tick(); #1;
        chk("to_c65_bus_err", bus_err, 32'd0);
        chk("to_c65_ramREN",  ramREN,  32'd0);
        chk("to_c65_iwait",   iwait,   32'd1);
        iREN = 1'b0; ramstate = FREE; ramload = '0;
        tick();

        // read+write together, then reset mid-service
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h55AA55AA; #1;
        chk("pe_c0_proto_err", proto_err, 32'd0);
        tick(); ramstate = BUSY; #1;
        chk("pe_c1_ramWEN",    ramWEN,    32'd1);
        chk("pe_c1_ramREN",    ramREN,    32'd0);
        chk("pe_c1_proto_err", proto_err, 32'd1);
        tick(); #1;
        RST = 1'b1; #1;
        chk("mr_ramWEN",    ramWEN,    32'd0);
        chk("mr_ramREN",    ramREN,    32'd0);
        chk("mr_dwait",     dwait,     32'd1);
        chk("mr_iwait",     iwait,     32'd1);
        chk("mr_ramaddr",   ramaddr,   32'd0);
        chk("mr_ramstore",  ramstore,  32'd0);
        chk("mr_dload",     dload,     32'd0);
        chk("mr_bus_err",   bus_err,   32'd0);
        chk("mr_proto_err", proto_err, 32'd0);
        dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        tick(); RST = 1'b0;
        tick(); #1;
        chk("post_rst_dwait",     dwait,     32'd1);
        chk("post_rst_proto_err", proto_err, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
